// File: rtl/mux_stream_rr_if.sv
// Stream bundle between N producers, the multiplexer and one consumer.
// Signal names are from the multiplexer's point of view.
interface mux_stream_rr_if #(
    parameter int NUM_CH = 4,
    parameter int DW     = 8
);
    localparam int SELW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                   i_mode;
    logic [SELW-1:0]        i_sel;
    logic [NUM_CH-1:0]      i_valid;
    logic [NUM_CH-1:0]      o_ready;
    logic [NUM_CH*DW-1:0]   i_data;
    logic                   o_valid;
    logic                   i_ready;
    logic [DW-1:0]          o_data;
    logic [SELW-1:0]        o_ch;

    modport master (
        output i_mode, i_sel, i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_data, o_ch
    );

    modport slave (
        input  i_mode, i_sel, i_valid, i_data, i_ready,
        output o_ready, o_valid, o_data, o_ch
    );
endinterface

// File: rtl/mux_stream_rr.sv
// N-channel registered stream multiplexer: fixed-select or round-robin
// arbitration feeding a single one-entry output register.
module mux_stream_rr #(
    parameter int NUM_CH = 4,
    parameter int DW     = 8
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    mux_stream_rr_if.slave bus
);
    localparam int SELW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [SELW-1:0] ptr_q, ptr_d;
    logic [SELW-1:0] ch_q, ch_d;
    logic [DW-1:0]   data_q, data_d;
    logic            valid_q, valid_d;

    logic            gnt_vld;
    logic [SELW-1:0] gnt_idx;
    logic [DW-1:0]   gnt_data;
    logic [SELW:0]   rr_sum;
    logic [SELW-1:0] rr_idx;
    logic            accept;
    logic            xfer_in;

    // Grant: an out-of-range select matches no channel, so it never grants.
    // The round-robin search runs from the farthest offset down so the
    // nearest valid channel at or after ptr is the one left standing.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        rr_sum  = '0;
        rr_idx  = '0;
        if (!bus.i_mode) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (bus.i_sel == SELW'(k) && bus.i_valid[k]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SELW'(k);
                end
            end
        end else begin
            for (int off = NUM_CH - 1; off >= 0; off--) begin
                rr_sum = {1'b0, ptr_q} + (SELW+1)'(off);
                if (rr_sum >= (SELW+1)'(NUM_CH))
                    rr_sum = rr_sum - (SELW+1)'(NUM_CH);
                rr_idx = rr_sum[SELW-1:0];
                if (bus.i_valid[rr_idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = rr_idx;
                end
            end
        end
    end

    assign accept  = ~valid_q | bus.i_ready;
    assign xfer_in = accept & gnt_vld;

    always_comb begin
        gnt_data    = '0;
        bus.o_ready = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (gnt_idx == SELW'(k)) begin
                gnt_data       = bus.i_data[k*DW +: DW];
                bus.o_ready[k] = xfer_in;
            end
        end
    end

    always_comb begin
        valid_d = xfer_in | (valid_q & ~bus.i_ready);
        data_d  = xfer_in ? gnt_data : data_q;
        ch_d    = xfer_in ? gnt_idx  : ch_q;
        ptr_d   = ptr_q;
        if (xfer_in && bus.i_mode)
            ptr_d = (gnt_idx == SELW'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.o_valid = valid_q;
    assign bus.o_data  = data_q;
    assign bus.o_ch    = ch_q;
endmodule

// File: doc/mux_stream_rr.md
Name: mux_stream_rr

Overview:
Parametrised N-channel registered stream multiplexer with valid/ready handshake on every input and on the output. It operates in one of two modes:
- Fixed-select: the channel is chosen by i_sel.
- Round-robin: fair arbitration among valid channels.

It sits between several producer streams and a single consumer. It is the sequential, multi-channel successor to the team's 2:1 combinational mux.

Parameters:
NUM_CH, 4, number of input channels (2..16)
DW, 8, data width per channel in bits
SELW, $clog2(NUM_CH), select/channel-index width (localparam, derived; minimum 1)

Ports:
i_clk  input  1  clock, all state on rising edge
i_rstn  input  1  asynchronous active-low reset
i_mode  input  1  0 = fixed-select, 1 = round-robin
i_sel  input  SELW  channel index used when i_mode=0
i_valid  input  NUM_CH  per-channel valid, bit k = channel k
o_ready  output  NUM_CH  per-channel ready, bit k = channel k
i_data  input  NUM_CH*DW  packed data, channel k at bits [k*DW +: DW]
o_valid  output  1  output register holds a word
i_ready  input  1  consumer ready
o_data  output  DW  registered output data
o_ch  output  SELW  index of channel that supplied o_data

Behaviour:
Reset:
- While i_rstn=0: o_valid=0, o_data=0, o_ch=0, round-robin pointer=0.
- Reset asserted mid-transfer discards the held word. No partial state survives.

Output stage:
- Single output register, one entry.
- accept = ~o_valid | i_ready.
- Output transfer occurs when o_valid & i_ready.

Grant (combinational):
- Fixed mode: grant = i_sel when i_sel < NUM_CH and i_valid[i_sel]=1. Otherwise no grant. Out-of-range i_sel never grants.
- Round-robin mode: grant = first k with i_valid[k]=1, searching from ptr upward with wrap (ptr, ptr+1, ..., NUM_CH-1, 0, ..., ptr-1). No valid bits means no grant.

Handshakes:
- o_ready[k] = accept & (grant==k). At most one o_ready bit is high in any cycle.
- o_ready must not depend combinationally on i_valid of any channel other than through the grant logic. o_ready never depends on i_data.

Input transfer (i_valid[g] & o_ready[g]):
- Next cycle: o_valid=1, o_data=channel g data, o_ch=g.
- Latency from input transfer to o_valid is 1 cycle.
- Throughput is 1 word per cycle when i_ready is held at 1.

Hold:
- While o_valid=1 and i_ready=0: o_data and o_ch stay stable, and no input is accepted.

Drain:
- Output transfer with no new input transfer: o_valid -> 0 next cycle.
- Simultaneous output transfer and input transfer: new word loaded, o_valid stays 1.

Round-robin pointer:
- ptr <= (g+1) mod NUM_CH, only on an input transfer in round-robin mode.
- ptr is unchanged in fixed mode and on cycles without a transfer.

Mode / select changes:
- i_mode or i_sel may change on any cycle. The change affects only the grant of that same cycle.
- A held output word is never altered by a mode or select change.

Data integrity:
- No word is duplicated or dropped. Each accepted input word appears exactly once at the output, in acceptance order.

Test Plan:
- Reset: assert i_rstn=0 while o_valid=1 -> o_valid=0, o_data=0, o_ch=0 immediately. After release, round-robin grants channel 0 first when all valid.
- Fixed mode: NUM_CH=4, i_sel=2, i_valid=4'b1111, ch2 data=8'hA5, i_ready=1 -> o_ready=4'b0100. Next cycle o_valid=1, o_data=8'hA5, o_ch=2. Setting i_sel=3 with i_valid[3]=0 -> o_ready=0, o_valid drops after drain.
- Round-robin fairness: i_valid=4'b1011 held, i_ready=1 for 6 cycles -> o_ch sequence 0,1,3,0,1,3 with a word every cycle.
- Backpressure: o_valid=1 from ch1 data 8'h3C, i_ready=0 for 5 cycles -> o_data=8'h3C and o_ch=1 stable, o_ready=0. On i_ready=1, a new word loads the same cycle (o_valid stays 1).
- Out-of-range select: parameterise NUM_CH=3 (SELW=2), i_mode=0, i_sel=3, all valid -> o_ready=3'b000, o_valid stays 0.
- Mode switch: round-robin with ptr=2, i_valid all 1; switch to i_mode=0, i_sel=0 for 2 cycles, then back to round-robin -> o_ch sequence 0,0,2: ptr is not advanced by fixed-mode grants.
